// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding arbiter of the shared memory port, load/store priority with fetch starvation guard and timeout.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input logic clk,
    input logic rst,
    input logic en,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        owner_ls_q, owner_ls_d;
    logic        store_q, store_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        pick_if, go_st, done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_ls_q   <= 1'b0;
            store_q      <= 1'b0;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_ls_q   <= owner_ls_d;
            store_q      <= store_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_ls_d    = owner_ls_q;
        store_d       = store_q;
        starve_cnt_d  = starve_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pick_if       = bus.if_req && (!bus.ls_req || starve_cnt_q == STARVE_LIM);
        go_st         = !pick_if && bus.ls_we;
        done          = bus.mem_rvalid || (wait_cnt_q + 8'd1 == WAIT_LAST);
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.ls_gnt    = 1'b0;
        bus.ls_rvalid = 1'b0;
        bus.ls_rdata  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.bus_err   = 1'b0;
        // Outputs stay silent while reset is held, whatever the stale state says.
        if (rst) begin
            if (state_q == IDLE) begin
                if (en && (bus.if_req || bus.ls_req)) begin
                    bus.mem_req   = 1'b1;
                    bus.if_gnt    = pick_if;
                    bus.ls_gnt    = !pick_if;
                    bus.mem_we    = go_st;
                    bus.mem_addr  = pick_if ? bus.if_addr : bus.ls_addr;
                    bus.mem_wdata = go_st ? bus.ls_wdata : '0;
                    bus.mem_wstrb = go_st ? bus.ls_wstrb : '0;
                    owner_ls_d    = !pick_if;
                    store_d       = go_st;
                    state_d       = WAIT;
                    wait_cnt_d    = '0;
                    starve_cnt_d  = (pick_if || !bus.if_req) ? '0 :
                                    (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
                end
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (done) begin
                    bus.if_rvalid = !owner_ls_q;
                    bus.ls_rvalid = owner_ls_q;
                    bus.if_rdata  = (!owner_ls_q && bus.mem_rvalid) ? bus.mem_rdata : '0;
                    bus.ls_rdata  = (owner_ls_q && !store_q && bus.mem_rvalid) ? bus.mem_rdata : '0;
                    bus.bus_err   = !bus.mem_rvalid;
                    state_d       = IDLE;
                end
            end
        end
    end
endmodule
